// File: rtl/lut_neuron_prog_pkg.sv
// Shared definitions for the programmable LUT neuron.
//   state_e      : block state {EMPTY, LOAD, RUN}
//   table_depth(): number of table entries for a given input width
//   DEF_IN_BITS / DEF_OUT_BITS : default neuron geometry used by the layer generator
package lut_neuron_prog_pkg;

  localparam int DEF_IN_BITS  = 7;
  localparam int DEF_OUT_BITS = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_e;

  function automatic int table_depth(input int in_bits);
    return 1 << in_bits;
  endfunction

endpackage

// File: rtl/lut_neuron_prog_if.sv
// Bus bundle for the programmable LUT neuron.
//   prog_* : serial table programming stream (start pulse, valid/data, done pulse, loaded)
//   in_*   : query request (valid/ready, address = neuron input vector)
//   out_*  : query response (valid/ready, table entry)
// master = traffic source / sink around the neuron, slave = the neuron itself.
interface lut_neuron_prog_if
  import lut_neuron_prog_pkg::*;
#(
  parameter int IN_BITS  = DEF_IN_BITS,
  parameter int OUT_BITS = DEF_OUT_BITS
);
  logic                prog_start;
  logic                prog_valid;
  logic [OUT_BITS-1:0] prog_data;
  logic                prog_done;
  logic                loaded;
  logic                in_valid;
  logic                in_ready;
  logic [IN_BITS-1:0]  in_data;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_BITS-1:0] out_data;

  modport master (
    output prog_start, prog_valid, prog_data, in_valid, in_data, out_ready,
    input  prog_done, loaded, in_ready, out_valid, out_data
  );

  modport slave (
    input  prog_start, prog_valid, prog_data, in_valid, in_data, out_ready,
    output prog_done, loaded, in_ready, out_valid, out_data
  );
endinterface

// File: rtl/lut_neuron_ram.sv
// Truth-table storage: 2^IN_BITS x OUT_BITS distributed RAM.
//   clk   : write clock
//   we    : write enable, waddr/wdata : synchronous write port
//   raddr : asynchronous read address, rdata : read data
// Contents are intentionally not reset; they are only meaningful after a full load.
module lut_neuron_ram
  import lut_neuron_prog_pkg::*;
#(
  parameter int IN_BITS  = DEF_IN_BITS,
  parameter int OUT_BITS = DEF_OUT_BITS
) (
  input  logic                clk,
  input  logic                we,
  input  logic [IN_BITS-1:0]  waddr,
  input  logic [OUT_BITS-1:0] wdata,
  input  logic [IN_BITS-1:0]  raddr,
  output logic [OUT_BITS-1:0] rdata
);
  localparam int DEPTH = table_depth(IN_BITS);

  logic [OUT_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lut_neuron_prog.sv
// Runtime-programmable LUT neuron.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of lut_neuron_prog_if
//     - prog_start restarts a full serial load from address 0
//     - each prog_valid in LOAD writes one word; the last word moves to RUN
//       and pulses prog_done in the following cycle
//     - in RUN, queries go through a one-deep registered output stage
//       (in_ready = !out_valid || out_ready), one result per cycle
module lut_neuron_prog
  import lut_neuron_prog_pkg::*;
#(
  parameter int IN_BITS  = DEF_IN_BITS,
  parameter int OUT_BITS = DEF_OUT_BITS
) (
  input  logic clk,
  input  logic rst_n,
  lut_neuron_prog_if.slave bus
);
  localparam int DEPTH = table_depth(IN_BITS);
  localparam int CW    = IN_BITS + 1;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic                prog_done_q;
  logic                out_valid_q;
  logic [OUT_BITS-1:0] out_data_q;
  logic [OUT_BITS-1:0] rd_data;

  logic wr_en;      // table write this cycle
  logic last_wr;    // write of the final table word
  logic in_ready;
  logic accept;
  logic consume;

  // A prog_start always wins over a same-cycle prog_valid, so that word is dropped.
  assign last_wr = wr_en && (cnt_q == CW'(DEPTH - 1));
  assign accept  = bus.in_valid && in_ready;
  assign consume = out_valid_q && bus.out_ready;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (bus.prog_start) state_d = LOAD;
      LOAD:  if (bus.prog_start) state_d = LOAD;
             else if (last_wr)   state_d = RUN;
      RUN:   if (bus.prog_start) state_d = LOAD;
      default:                   state_d = EMPTY;
    endcase
  end

  always_comb begin
    wr_en    = 1'b0;
    in_ready = 1'b0;
    unique case (state_q)
      LOAD:    wr_en    = bus.prog_valid && !bus.prog_start;
      RUN:     in_ready = !out_valid_q || bus.out_ready;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- load counter
  // One bit wider than the address so the terminal value is distinct from 0;
  // the FSM leaves LOAD on the last write, so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      prog_done_q <= 1'b0;
    end else begin
      prog_done_q <= last_wr;
      if (bus.prog_start) cnt_q <= '0;
      else if (wr_en)     cnt_q <= cnt_q + CW'(1);
    end
  end

  // ---------------------------------------------------------------- table
  lut_neuron_ram #(
    .IN_BITS  (IN_BITS),
    .OUT_BITS (OUT_BITS)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (cnt_q[IN_BITS-1:0]),
    .wdata (bus.prog_data),
    .raddr (bus.in_data),
    .rdata (rd_data)
  );

  // ---------------------------------------------------------------- output stage
  // Independent of state: a result accepted in RUN is still held (and may be
  // consumed) after a reload starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= rd_data;
    end else if (consume) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.loaded    = (state_q == RUN);
  assign bus.prog_done = prog_done_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule
